// File: rtl/uart_rx_os.sv
// uart_rx_os: oversampling UART receiver (8N1) with ready/clear handshake and sticky status flags.
// Define UART_RX_PARITY_EN to receive 8E1 frames; otherwise no parity bit is expected and parity_err is 0.
module uart_rx_os #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 rx,
  input  logic                 en_clk,
  input  logic                 ready_clr,
  output logic                 ready,
  output logic [DATA_BITS-1:0] dout,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 parity_err
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [CW-1:0] CNT_HALF = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [BW-1:0] IDX_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] IDX_ONE  = BW'(1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t               state_reg, state_next;
  logic [CW-1:0]        cnt_reg, cnt_next;
  logic [BW-1:0]        bit_idx_reg, bit_idx_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic [DATA_BITS-1:0] dout_reg, dout_next;
  logic                 ready_reg, ready_next;
  logic                 frame_err_reg, frame_err_next;
  logic                 overrun_reg, overrun_next;
  logic [1:0]           sync_reg;
  logic                 rx_s;

`ifdef UART_RX_PARITY_EN
  logic                 par_bad_reg, par_bad_next;
  logic                 parity_err_reg, parity_err_next;
`endif

  // Two-flop synchronizer; idles high so reset never looks like a start bit.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_reg <= '1;
    end else begin
      sync_reg <= {sync_reg[0], rx};
    end
  end

  assign rx_s = sync_reg[1];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      bit_idx_reg    <= '0;
      shift_reg      <= '0;
      dout_reg       <= '0;
      ready_reg      <= 1'b0;
      frame_err_reg  <= 1'b0;
      overrun_reg    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_reg    <= 1'b0;
      parity_err_reg <= 1'b0;
`endif
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      bit_idx_reg    <= bit_idx_next;
      shift_reg      <= shift_next;
      dout_reg       <= dout_next;
      ready_reg      <= ready_next;
      frame_err_reg  <= frame_err_next;
      overrun_reg    <= overrun_next;
`ifdef UART_RX_PARITY_EN
      par_bad_reg    <= par_bad_next;
      parity_err_reg <= parity_err_next;
`endif
    end
  end

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    bit_idx_next    = bit_idx_reg;
    shift_next      = shift_reg;
    dout_next       = dout_reg;
    ready_next      = ready_reg;
    frame_err_next  = frame_err_reg;
    overrun_next    = overrun_reg;
`ifdef UART_RX_PARITY_EN
    par_bad_next    = par_bad_reg;
    parity_err_next = parity_err_reg;
`endif

    // Clear first so that a completion on the same edge takes precedence.
    if (ready_clr) begin
      ready_next     = 1'b0;
      frame_err_next = 1'b0;
      overrun_next   = 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_next = 1'b0;
`endif
    end

    if (en_clk) begin
      cnt_next = cnt_reg + CNT_ONE;
      case (state_reg)
        IDLE: begin
          if (!rx_s) begin
            cnt_next   = '0;
            state_next = START;
          end
        end
        START: begin
          if (cnt_reg == CNT_HALF) begin
            if (!rx_s) begin
              cnt_next     = '0;
              bit_idx_next = '0;
              state_next   = DATA;
            end else begin
              state_next = IDLE;
            end
          end
        end
        DATA: begin
          if (cnt_reg == CNT_LAST) begin
            shift_next   = {rx_s, shift_reg[DATA_BITS-1:1]};
            bit_idx_next = bit_idx_reg + IDX_ONE;
            if (bit_idx_reg == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_next = PARITY;
`else
              state_next = STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt_reg == CNT_LAST) begin
            par_bad_next = ^{shift_reg, rx_s};
            state_next   = STOP;
          end
        end
`endif
        STOP: begin
          if (cnt_reg == CNT_LAST) begin
            state_next = IDLE;
            if (rx_s) begin
              dout_next  = shift_reg;
              ready_next = 1'b1;
              // A simultaneous clear counts as the previous byte being consumed.
              if (ready_reg && !ready_clr) begin
                overrun_next = 1'b1;
              end
`ifdef UART_RX_PARITY_EN
              if (par_bad_reg) begin
                parity_err_next = 1'b1;
              end
`endif
            end else begin
              frame_err_next = 1'b1;
            end
          end
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  assign ready     = ready_reg;
  assign dout      = dout_reg;
  assign frame_err = frame_err_reg;
  assign overrun   = overrun_reg;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_reg;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_os.sv
// tb_uart_rx_os: directed table, hand sequences and randomized frames for uart_rx_os,
// checked against a frame-level model of the receiver's outputs.
module tb_uart_rx_os;

  localparam int DW = 8;
  localparam int OS = 16;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS   = DW + 3;
  localparam bit HAS_PAR = 1'b1;
`else
  localparam int NBITS   = DW + 2;
  localparam bit HAS_PAR = 1'b0;
`endif
  // Cycles from the start-bit edge to the completion edge: two synchronizer
  // flops plus the IDLE detection tick, then the middle of the stop bit.
  localparam int DONE_OFF = 3 + OS * (NBITS - 1) + OS / 2;
  localparam int BRK_LEN  = 640;

  logic          CLK = 1'b0;
  logic          RST;
  logic          rx;
  logic          en_clk;
  logic          ready_clr;
  logic          ready;
  logic [DW-1:0] dout;
  logic          frame_err;
  logic          overrun;
  logic          parity_err;

  int checks   = 0;
  int failures = 0;

  logic       m_ready;
  logic [7:0] m_dout;
  logic       m_fe;
  logic       m_ov;
  logic       m_pe;

  typedef struct {
    bit         op_clr;
    logic [7:0] data;
    bit         stop_ok;
    bit         par_ok;
    logic       e_ready;
    logic [7:0] e_dout;
    logic       e_fe;
    logic       e_ov;
    logic       e_pe;
  } row_t;

  row_t rows[10];

  always #5 CLK = ~CLK;

  uart_rx_os #(.DATA_BITS(DW), .OVERSAMPLE(OS)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .rx        (rx),
    .en_clk    (en_clk),
    .ready_clr (ready_clr),
    .ready     (ready),
    .dout      (dout),
    .frame_err (frame_err),
    .overrun   (overrun),
    .parity_err(parity_err)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_exp(input string name, input logic r, input logic [7:0] d,
                           input logic fe, input logic ov, input logic pe);
    chk($sformatf("%s.ready", name), ready, r);
    chk($sformatf("%s.dout", name), dout, d);
    chk($sformatf("%s.frame_err", name), frame_err, fe);
    chk($sformatf("%s.overrun", name), overrun, ov);
    chk($sformatf("%s.parity_err", name), parity_err, pe);
  endtask

  task automatic check_model(input string name);
    check_exp(name, m_ready, m_dout, m_fe, m_ov, m_pe);
  endtask

  task automatic m_clear();
    m_ready = 1'b0;
    m_fe    = 1'b0;
    m_ov    = 1'b0;
    m_pe    = 1'b0;
  endtask

  // One frame's effect on the outputs; clr_same means ready_clr hit the completion edge.
  task automatic m_frame(input logic [7:0] d, input bit stop_ok, input bit par_ok, input bit clr_same);
    bit prev_ready;
    prev_ready = m_ready && !clr_same;
    if (clr_same) m_clear();
    if (stop_ok) begin
      m_ov    = m_ov | prev_ready;
      m_ready = 1'b1;
      m_dout  = d;
      if (HAS_PAR && !par_ok) m_pe = 1'b1;
    end else begin
      m_fe = 1'b1;
    end
  endtask

  task automatic idle(input int n, input int div);
    rx        = 1'b1;
    ready_clr = 1'b0;
    for (int i = 0; i < n; i++) begin
      en_clk = ((i % div) == 0);
      tick();
    end
  endtask

  task automatic pulse_clr();
    en_clk    = 1'b1;
    ready_clr = 1'b1;
    tick();
    ready_clr = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] data, input bit stop_ok, input bit par_ok,
                            input int div, input int clr_at, input int abort_at, input bit lat_chk);
    logic [NBITS-1:0] bits;
    bits[0] = 1'b0;
    for (int j = 0; j < DW; j++) bits[1+j] = data[j];
    bits[DW+1]    = (^data) ^ !par_ok;
    bits[NBITS-1] = stop_ok;
    for (int i = 0; i < NBITS * OS * div; i++) begin
      if (i == abort_at) begin
        ready_clr = 1'b0;
        return;
      end
      rx        = bits[i / (OS * div)];
      en_clk    = ((i % div) == 0);
      ready_clr = (i == clr_at);
      tick();
      if (lat_chk && (i + 1 == DONE_OFF - 1)) chk("latency_before", ready, 1'b0);
      if (lat_chk && (i + 1 == DONE_OFF)) chk("latency_at", ready, 1'b1);
    end
    rx        = 1'b1;
    ready_clr = 1'b0;
    $display("frame data=%02h stop=%0d par_ok=%0d div=%0d -> ready=%0d dout=%02h fe=%0d ov=%0d pe=%0d",
             data, stop_ok, par_ok, div, ready, dout, frame_err, overrun, parity_err);
  endtask

  initial begin
    int errs;
    int lo;
    int hi;
    logic [7:0] d;
    bit stop_ok;
    bit par_ok;
    bit clr_before;
    bit clr_same;
    int div;

    rows[0] = '{1'b0, 8'hA5, 1'b1, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0};
    rows[1] = '{1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0};
    rows[2] = '{1'b0, 8'h3C, 1'b1, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0};
    rows[3] = '{1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0};
    rows[4] = '{1'b0, 8'h55, 1'b0, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b0, 1'b0};
    rows[5] = '{1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0};
    rows[6] = '{1'b0, 8'h12, 1'b1, 1'b1, 1'b1, 8'h12, 1'b0, 1'b0, 1'b0};
    rows[7] = '{1'b0, 8'h34, 1'b1, 1'b1, 1'b1, 8'h34, 1'b0, 1'b1, 1'b0};
    rows[8] = '{1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 8'h34, 1'b0, 1'b0, 1'b0};
    rows[9] = '{1'b0, 8'h99, 1'b1, 1'b1, 1'b1, 8'h99, 1'b0, 1'b0, 1'b0};

    RST       = 1'b1;
    rx        = 1'b1;
    en_clk    = 1'b0;
    ready_clr = 1'b0;
    m_clear();
    m_dout = 8'h00;
    repeat (3) tick();
    check_exp("reset", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    RST = 1'b0;
    idle(20, 1);

    // Short low pulse: a false start that must be rejected silently.
    rx     = 1'b0;
    en_clk = 1'b1;
    repeat (4) tick();
    idle(40, 1);
    $display("glitch rx low 4 ticks -> ready=%0d fe=%0d", ready, frame_err);
    check_exp("glitch", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    for (int r = 0; r < 10; r++) begin
      if (rows[r].op_clr) begin
        pulse_clr();
        m_clear();
        idle(8, 1);
        $display("ready_clr -> ready=%0d fe=%0d ov=%0d", ready, frame_err, overrun);
      end else begin
        send_frame(rows[r].data, rows[r].stop_ok, rows[r].par_ok, 1, -1, -1, (r == 0));
        m_frame(rows[r].data, rows[r].stop_ok, rows[r].par_ok, 1'b0);
        idle(24, 1);
      end
      check_exp($sformatf("row%0d", r), rows[r].e_ready, rows[r].e_dout,
                rows[r].e_fe, rows[r].e_ov, rows[r].e_pe);
    end

    // ready_clr on exactly the completion edge while a byte is already pending.
    send_frame(8'h7E, 1'b1, 1'b1, 1, DONE_OFF - 1, -1, 1'b0);
    m_frame(8'h7E, 1'b1, 1'b1, 1'b1);
    idle(24, 1);
    check_exp("clr_on_done", 1'b1, 8'h7E, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of the data bits of 0xFF.
    send_frame(8'hFF, 1'b1, 1'b1, 1, OS * 4, OS * 4, 1'b0);
    RST = 1'b1;
    #1;
    $display("reset mid-frame -> ready=%0d dout=%02h", ready, dout);
    check_exp("rst_mid", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    tick();
    RST = 1'b0;
    m_clear();
    m_dout = 8'h00;
    idle(30, 1);
    send_frame(8'h81, 1'b1, 1'b0, 1, -1, -1, 1'b0);
    m_frame(8'h81, 1'b1, 1'b0, 1'b0);
    idle(24, 1);
    check_exp("after_rst", 1'b1, 8'h81, 1'b0, 1'b0, HAS_PAR);

    // Break: one frame error per frame length, then recovery.
    pulse_clr();
    m_clear();
    errs = 0;
    rx   = 1'b0;
    for (int i = 0; i < BRK_LEN; i++) begin
      en_clk    = 1'b1;
      ready_clr = frame_err;
      if (frame_err) errs++;
      tick();
    end
    ready_clr = 1'b0;
    lo = BRK_LEN / (OS * NBITS) - 1;
    hi = BRK_LEN / (OS * (NBITS - 1)) + 1;
    $display("break %0d cycles -> frame errors=%0d", BRK_LEN, errs);
    chk("break_err_count_in_range", (errs >= lo && errs <= hi), 1'b1);
    idle(400, 1);
    pulse_clr();
    idle(4, 1);
    chk("break_clr.ready", ready, 1'b0);
    chk("break_clr.frame_err", frame_err, 1'b0);
    send_frame(8'h5A, 1'b1, 1'b1, 1, -1, -1, 1'b0);
    m_frame(8'h5A, 1'b1, 1'b1, 1'b0);
    idle(24, 1);
    check_model("after_break");

    for (int n = 0; n < 14; n++) begin
      d          = 8'($urandom);
      stop_ok    = ($urandom_range(0, 4) != 0);
      par_ok     = ($urandom_range(0, 4) != 0);
      div        = $urandom_range(1, 2);
      clr_before = ($urandom_range(0, 1) == 1);
      clr_same   = (div == 1) && ($urandom_range(0, 3) == 0);
      if (clr_before) begin
        pulse_clr();
        m_clear();
        idle(4, 1);
      end
      send_frame(d, stop_ok, par_ok, div, clr_same ? DONE_OFF - 1 : -1, -1, 1'b0);
      m_frame(d, stop_ok, par_ok, clr_same);
      idle($urandom_range(24, 60) * div, div);
      check_model($sformatf("rand%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
